mips_data_memory: RTL
=====================

Name: mips_data_memory

Overview:
- Responder end of the core's data-memory port: services word loads/stores issued on mem_addr / mem_data_in / mem_write_en and returns read data on mem_data_out.
- Byte-addressed, big-endian, 4-byte word access, with a configurable multi-cycle latency and a ready handshake.
- Sits beside the core in the top level. It is also the memory model used by every core-level bench.

Parameters:
- ADDR_BITS, 12: byte-address width actually decoded; memory holds 2^ADDR_BITS bytes.
- LATENCY, 2: cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  synchronous active-low reset.
- mem_addr  input  32  byte address from core; bits [ADDR_BITS-1:0] decoded, upper bits ignored.
- mem_data_in  input  8 x [0:3]  write data; lane 0 = MSB = byte at mem_addr.
- mem_write_en  input  1  store request.
- mem_read_en  input  1  load request.
- halted  input  1  core halted; blocks new requests.
- mem_data_out  output  8 x [0:3]  read data; lane 0 = byte at address.
- mem_ready  output  1  one-cycle completion pulse.
- mem_misaligned  output  1  one-cycle pulse, coincident with mem_ready, for an unaligned request.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low on rst_b, sampled at posedge clk.
  - Reset values: state=IDLE, counter=0, mem_ready=0, mem_misaligned=0, mem_data_out all lanes 8'h00.
  - Memory array contents are NOT affected by reset.
- State machine: IDLE, BUSY.
- IDLE:
  - A request is accepted at a posedge when halted=0 and (mem_write_en | mem_read_en).
  - On acceptance, latch the address, the write data, and the op.
  - Write wins if both enables are high. The op is treated as a store; read data returns the newly written word.
  - Move to BUSY with counter=LATENCY-1.
- BUSY:
  - counter decrements each cycle.
  - When counter==0: commit the op, assert mem_ready for that single cycle, and return to IDLE.
  - Net timing: request accepted at edge N gives mem_ready high during the cycle after edge N+LATENCY-1. Bench check: ready observed at edge N+LATENCY.
  - With LATENCY=1 there is no dwell: ready is high in the cycle immediately following acceptance.
- Requests arriving while BUSY, or in the same cycle mem_ready is high, are ignored. The core must hold its request until it sees ready, then deassert or present the next one.
- Store commit: bytes at addr+0..addr+3 receive lanes 0..3, at the mem_ready cycle edge.
- Load commit: mem_data_out is loaded with bytes addr+0..addr+3. It is held unchanged until the next completed load, or a store with both enables set.
- Address handling:
  - Address = latched mem_addr[ADDR_BITS-1:0], so accesses alias modulo 2^ADDR_BITS.
  - Byte offsets wrap within the array: addr+k is taken mod 2^ADDR_BITS.
- Misaligned access (mem_addr[1:0] != 0):
  - Still completes with mem_ready after LATENCY.
  - mem_misaligned=1 in the same cycle.
  - No array write; mem_data_out unchanged.
- halted:
  - halted=1 in IDLE blocks acceptance.
  - An op already in BUSY completes normally.
- Reset mid-operation: the in-flight op is abandoned. No write commits, no mem_ready pulse, and mem_data_out is cleared.
- Any mem_ready is followed by at least one cycle of mem_ready=0 before the next pulse.

Test Plan:
- Reset, LATENCY=2: store 0xDEADBEEF at 0x010, then load 0x010. Required: ready 2 cycles after each acceptance; mem_data_out = {DE,AD,BE,EF}; mem_misaligned=0.
- Aliasing, ADDR_BITS=12: store 0x12345678 at 0x1010, then load 0x010. Required: returns {12,34,56,78}. Then load 0x014, previously 0: unchanged array neighbour, returns 0 if never written.
- Misaligned: store 0xCAFEF00D at 0x013. Required: mem_ready and mem_misaligned pulse together after 2 cycles. A subsequent load of 0x010 still returns the prior value.
- Busy collision: load 0x010 accepted; a store to 0x010 presented one cycle later while BUSY. Required: the store is ignored (no ready for it). The array is unchanged until the store is re-presented after ready.
- Halt and reset:
  - Assert halted, then present a load. Required: no acceptance, mem_ready stays 0.
  - Separately, pull rst_b low during BUSY of a store to 0x020. Required: next load of 0x020 returns the old contents; mem_data_out=0 after reset.
- Both enables: mem_read_en=mem_write_en=1 with data 0x0BADF00D at 0x030, LATENCY=1. Required: ready next cycle; mem_data_out = {0B,AD,F0,0D}; array updated.

Source files
------------

// File: rtl/mips_data_memory.sv
// mips_data_memory
//
// Data-memory responder for the core. It services word loads and stores over a
// byte-addressed, big-endian array, with a fixed multi-cycle latency and a
// one-cycle ready pulse when each access completes.
//
// Parameters
//   ADDR_BITS : byte-address width decoded. The array holds 2**ADDR_BITS bytes.
//   LATENCY   : cycles from request acceptance to mem_ready. Legal range 1..15.
//
// Ports
//   clk            : clock, rising edge
//   rst_b          : synchronous active-low reset. Array contents are preserved.
//   mem_addr       : byte address; bits above ADDR_BITS are ignored (aliasing)
//   mem_data_in    : write data; lane 0 (MSB) goes to the byte at mem_addr
//   mem_write_en   : store request; wins over mem_read_en when both are set
//   mem_read_en    : load request
//   halted         : core halted; blocks acceptance of new requests
//   mem_data_out   : load data; lane 0 holds the byte at the address
//   mem_ready      : one-cycle completion pulse
//   mem_misaligned : pulses with mem_ready when the completed address was unaligned
module mips_data_memory #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  input  logic            mem_read_en,
  input  logic            halted,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready,
  output logic            mem_misaligned
);

  localparam int unsigned MemBytes = 2 ** ADDR_BITS;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [0:3][7:0]        wdata_q;
  logic                   we_q;
  logic                   re_q;
  logic                   accept;
  logic                   done;
  logic                   misaligned_op;
  logic [ADDR_BITS-1:0]   byte_addr [4];
  logic [0:3][7:0]        rd_word;

  logic [7:0]             mem_q [MemBytes];

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_BITS];

  // Control: IDLE accepts, BUSY counts down and completes when the count reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!halted && (mem_write_en || mem_read_en)) begin
          accept  = 1'b1;
          state_d = StBusy;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte addresses wrap inside the array.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + ADDR_BITS'(k);
      rd_word[k]   = mem_q[byte_addr[k]];
    end
  end

  assign misaligned_op  = (addr_q[1:0] != 2'b00);
  // Ready is a Moore output of the final BUSY cycle, so LATENCY=1 gives ready
  // in the cycle right after acceptance.
  assign mem_ready      = done;
  assign mem_misaligned = done && misaligned_op;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      mem_data_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_addr[ADDR_BITS-1:0];
        wdata_q <= mem_data_in;
        we_q    <= mem_write_en;
        re_q    <= mem_read_en;
      end
      // With both enables set, the array is written at this same edge, so the
      // returned word comes from the latched write data.
      if (done && !misaligned_op && re_q) begin
        mem_data_out <= we_q ? wdata_q : rd_word;
      end
    end
  end

  // The array has no reset. A reset during the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_b && done && we_q && !misaligned_op) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[byte_addr[k]] <= wdata_q[k];
      end
    end
  end

endmodule
